note_voice: RTL



---
 rtl/note_pkg.sv | 28 ++
 rtl/note_voice_tone_divider.sv | 49 ++++
 rtl/note_voice.sv | 128 ++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared types and constants for the note_voice tone generator:
// note codes, the half-period pitch table and envelope states.
package note_pkg;

  typedef logic [3:0] note_code_t;

  localparam note_code_t NOTE_REST = 4'd0;
  localparam note_code_t NOTE_MIN  = 4'd1;
  localparam note_code_t NOTE_MAX  = 4'd8;

  localparam int HALF_W = 5;

  // Half-period in clock cycles for keys C4..C5 at a 10 kHz clock
  localparam logic [HALF_W-1:0] HALF_PERIOD [1:8] = '{
    5'd19, 5'd17, 5'd15, 5'd14, 5'd13, 5'd11, 5'd10, 5'd10
  };

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  function automatic logic note_valid(note_code_t c);
    return (c >= NOTE_MIN) && (c <= NOTE_MAX);
  endfunction

  function automatic logic [HALF_W-1:0] half_of(note_code_t c);
    return note_valid(c) ? HALF_PERIOD[c] : HALF_PERIOD[NOTE_MIN];
  endfunction

endpackage

// File: rtl/note_voice_tone_divider.sv
// Square-wave phase generator: counts down a half-period and toggles the
// phase on each expiry; a load restarts the wave high at a new pitch.
module tone_divider
  import note_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic              clear,
  input  logic [HALF_W-1:0] half,
  output logic              phase
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load) begin
      cnt_d   = half - HALF_W'(1);
      phase_d = 1'b1;
    end else if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (run) begin
      if (cnt_q == '0) begin
        cnt_d   = half - HALF_W'(1);
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q - HALF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/note_voice.sv
// Note-code to enveloped square-wave voice: registers the sequencer code,
// detects onsets and runs an attack/sustain/release amplitude envelope.
module note_voice
  import note_pkg::*;
#(
  parameter int ATTACK_TICKS  = 8,
  parameter int RELEASE_TICKS = 64,
  parameter int LEVEL_MAX     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] note_sustain,
  output logic       tone_out,
  output logic [3:0] level,
  output logic [3:0] sample,
  output logic       active
);

  localparam int TICK_W = 16;
  localparam logic [TICK_W-1:0] ATK_LAST = TICK_W'(ATTACK_TICKS - 1);
  localparam logic [TICK_W-1:0] REL_LAST = TICK_W'(RELEASE_TICKS - 1);
  localparam logic [3:0]        LVL_TOP  = 4'(LEVEL_MAX);

  env_state_t        state_q, state_d;
  note_code_t        note_q, prev_q, pitch_q, pitch_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        level_q, level_d, sample_q, sample_d;
  logic              onset, rest, phase;

  function automatic logic [3:0] sat_inc(logic [3:0] v);
    return (v >= LVL_TOP) ? LVL_TOP : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  always_comb begin
    rest     = !note_valid(note_q);
    onset    = !rest && (!note_valid(prev_q) || (prev_q != note_q));
    state_d  = state_q;
    level_d  = level_q;
    tick_d   = tick_q;
    pitch_d  = pitch_q;
    // Onset outranks any envelope tick landing on the same cycle; level is kept
    if (onset) begin
      state_d = ATTACK;
      tick_d  = '0;
      pitch_d = note_q;
    end else begin
      case (state_q)
        IDLE: level_d = 4'd0;
        ATTACK: begin
          if (rest) begin
            state_d = RELEASE;
            tick_d  = '0;
          end else begin
            if (tick_q >= ATK_LAST) begin
              tick_d  = '0;
              level_d = sat_inc(level_q);
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
            if (level_d >= LVL_TOP) begin
              state_d = SUSTAIN;
              level_d = LVL_TOP;
              tick_d  = '0;
            end
          end
        end
        SUSTAIN: begin
          level_d = LVL_TOP;
          if (rest) begin
            state_d = RELEASE;
            tick_d  = '0;
          end
        end
        RELEASE: begin
          if (tick_q >= REL_LAST) begin
            tick_d  = '0;
            level_d = sat_dec(level_q);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
          if (level_d == 4'd0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    sample_d = phase ? level_q : 4'd0;
  end

  tone_divider u_div (
    .clk   (clk),
    .rst   (rst),
    .load  (onset),
    .run   (state_q != IDLE),
    .clear (state_d == IDLE),
    .half  (half_of(onset ? note_q : pitch_q)),
    .phase (phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      note_q   <= NOTE_REST;
      prev_q   <= NOTE_REST;
      pitch_q  <= NOTE_REST;
      tick_q   <= '0;
      level_q  <= 4'd0;
      sample_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_sustain;
      prev_q   <= note_q;
      pitch_q  <= pitch_d;
      tick_q   <= tick_d;
      level_q  <= level_d;
      sample_q <= sample_d;
    end
  end

  assign tone_out = phase;
  assign level    = level_q;
  assign sample   = sample_q;
  assign active   = (state_q != IDLE);

endmodule
